fifo_read_ctrl: RTL and testbench

Read-side controller that sits directly downstream of the 4-entry, 8-bit synchronous byte FIFO stage.
- It shadows the FIFO's occupancy by watching the FIFO write strobe.
- It issues `fifo_r_en` only when a read is legal and will not be dropped.
- It captures the FIFO's registered read data and presents it to the consumer over a valid/ready handshake, through a 2-entry output buffer.
- It flags FIFO overflow, because the FIFO itself has no full/empty flags.

---
 rtl/fifo_read_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Purpose  : Read-side controller for a flagless byte FIFO. It shadows the
//            FIFO occupancy, issues safe reads, and feeds a 2-entry
//            valid/ready output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_w_en,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_out_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] occupancy,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];

    logic             w_pop;
    logic             w_push;
    logic [2:0]       w_pending;
    logic [1:0]       w_wr_idx;

    assign w_pop  = (bcnt_q != 2'd0) & m_ready;
    assign w_push = inflight_q;

    // Bytes that will sit in the buffer after this edge, before any new read
    assign w_pending = {1'b0, bcnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};

    assign fifo_r_en = rst & (cnt_q != '0) & ~fifo_w_en & (w_pending < 3'd2);

    // Slot for the incoming byte, after the head has been shifted out
    assign w_wr_idx = bcnt_q - {1'b0, w_pop};

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (fifo_w_en) begin
            if (cnt_q < c_depth) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (fifo_r_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        inflight_d = fifo_r_en;
        bcnt_d     = bcnt_q + {1'b0, w_push} - {1'b0, w_pop};
        if (w_pop) begin
            buf_d[0] = buf_q[1];
        end
        if (w_push) begin
            if (w_wr_idx == 2'd0) begin
                buf_d[0] = fifo_out_data;
            end else begin
                buf_d[1] = fifo_out_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            bcnt_q     <= 2'd0;
            overflow_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            bcnt_q     <= bcnt_d;
            overflow_q <= overflow_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    assign m_data    = buf_q[0];
    assign m_valid   = (bcnt_q != 2'd0);
    assign occupancy = cnt_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Purpose  : Scoreboard bench for fifo_read_ctrl with a behavioural 4x8 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fifo_w_en = 1'b0;
    logic             fifo_r_en;
    logic [WIDTH-1:0] fifo_in_data = '0;
    logic [WIDTH-1:0] fifo_out_data;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [CNT_W-1:0] occupancy;
    logic             overflow;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic             sb_on = 1'b1;

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [1:0]       wp, rp;

    always #5 clk = ~clk;

    fifo_read_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_w_en    (fifo_w_en),
        .fifo_r_en    (fifo_r_en),
        .fifo_out_data(fifo_out_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .occupancy    (occupancy),
        .overflow     (overflow)
    );

    // Upstream FIFO: write priority, registered read data, wrapping pointers
    always @(posedge clk) begin
        if (!rst) begin
            wp            <= 2'd0;
            rp            <= 2'd0;
            fifo_out_data <= '0;
        end else if (fifo_w_en) begin
            fifo_mem[wp] <= fifo_in_data;
            wp           <= wp + 2'd1;
        end else if (fifo_r_en) begin
            fifo_out_data <= fifo_mem[rp];
            rp            <= rp + 2'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got byte 0x%0h expected none", m_data);
            end else begin
                check("sb_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r);
        fifo_w_en    = w;
        fifo_in_data = d;
        m_ready      = r;
        if (w && rst && sb_on) exp_q.push_back(d);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        drive(1'b0, '0, r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int reads;

        // Reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fifo_w_en    = 1'($urandom_range(0, 1));
            fifo_in_data = 8'($urandom);
            m_ready      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_r_en", fifo_r_en, 0);
            if (i == 1) begin
                check("rst_m_valid", m_valid, 0);
                check("rst_m_data", m_data, 0);
                check("rst_occupancy", occupancy, 0);
                check("rst_overflow", overflow, 0);
            end
            nxt();
        end
        rst = 1'b1;

        // Single byte: read in cycle 1, valid in cycle 3
        drive(1'b1, 8'hA5, 1'b1);
        @(negedge clk); check("sb1_r_en_c0", fifo_r_en, 0); nxt();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk); check("sb1_r_en_c1", fifo_r_en, 1); check("sb1_occ_c1", occupancy, 1); nxt();
        @(negedge clk); check("sb1_valid_c2", m_valid, 0); check("sb1_occ_c2", occupancy, 0); nxt();
        @(negedge clk); check("sb1_valid_c3", m_valid, 1); check("sb1_data_c3", m_data, 8'hA5); nxt();
        @(negedge clk); check("sb1_valid_c4", m_valid, 0); nxt();

        // Backpressure: four writes, only two reads fit behind a stalled consumer
        reads = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(17 * (i + 1)), 1'b0);
            @(negedge clk); reads += int'(fifo_r_en); nxt();
        end
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); reads += int'(fifo_r_en); nxt();
        end
        @(negedge clk);
        check("bp_reads", reads, 2);
        check("bp_occ", occupancy, 2);
        check("bp_valid", m_valid, 1);
        check("bp_head", m_data, 8'h11);
        check("bp_r_en_full", fifo_r_en, 0);
        nxt();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("bp_stream_valid", m_valid, 1); nxt();
        end
        @(negedge clk);
        check("bp_drained_valid", m_valid, 0);
        check("bp_queue_empty", exp_q.size(), 0);
        nxt();

        // Write priority blocks a read for exactly one cycle
        drive(1'b1, 8'h5A, 1'b1);
        @(negedge clk); nxt();
        drive(1'b1, 8'h6B, 1'b1);
        @(negedge clk); check("wp_blocked", fifo_r_en, 0); nxt();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk); check("wp_issue", fifo_r_en, 1); nxt();
        @(negedge clk); check("wp_issue2", fifo_r_en, 1); nxt();
        idle(4, 1'b1);
        @(negedge clk);
        check("wp_queue_empty", exp_q.size(), 0);
        check("wp_occ", occupancy, 0);
        check("wp_valid", m_valid, 0);
        nxt();

        // Overflow: fifth back-to-back write
        sb_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0);
            @(negedge clk);
            if (i == 4) begin
                check("ov_pre_flag", overflow, 0);
                check("ov_pre_occ", occupancy, 4);
            end
            nxt();
        end
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk); check("ov_flag", overflow, 1); check("ov_occ", occupancy, 4); nxt();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("ov_sticky", overflow, 1); nxt();
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk); check("ov_rst_r_en", fifo_r_en, 0); nxt();
        rst   = 1'b1;
        sb_on = 1'b1;
        @(negedge clk);
        check("ov_cleared", overflow, 0);
        check("ov_rst_occ", occupancy, 0);
        check("ov_rst_valid", m_valid, 0);
        nxt();

        // Reset in the cycle after a read: in-flight byte must be dropped
        drive(1'b1, 8'h77, 1'b1);
        @(negedge clk); nxt();
        drive(1'b1, 8'h88, 1'b1);
        @(negedge clk); nxt();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk); check("mr_r_en", fifo_r_en, 1); nxt();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk); check("mr_r_en_rst", fifo_r_en, 0); nxt();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_no_stale", m_valid, 0);
            check("mr_occ", occupancy, 0);
            nxt();
        end

        // Controller still delivers after the mid-stream reset
        drive(1'b1, 8'h3C, 1'b1);
        @(negedge clk); nxt();
        idle(5, 1'b1);
        check("post_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
